// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war round referee.
//   winner_t : who took the current round (11 is never produced)
//   state_t  : referee FSM states
//   seg7()   : hex digit to active-low 7-segment pattern, bit0 = seg a .. bit6 = seg g
package tug_pkg;

    typedef enum logic [1:0] {
        W_NONE  = 2'b00,
        W_LEFT  = 2'b01,
        W_RIGHT = 2'b10
    } winner_t;

    typedef enum logic [1:0] {
        PLAY,
        WIN,
        RESTART,
        DONE
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'h0:    segs = 7'b1000000;
            4'h1:    segs = 7'b1111001;
            4'h2:    segs = 7'b0100100;
            4'h3:    segs = 7'b0110000;
            4'h4:    segs = 7'b0011001;
            4'h5:    segs = 7'b0010010;
            4'h6:    segs = 7'b0000010;
            4'h7:    segs = 7'b1111000;
            4'h8:    segs = 7'b0000000;
            4'h9:    segs = 7'b0010000;
            4'hA:    segs = 7'b0001000;
            4'hB:    segs = 7'b0000011;
            4'hC:    segs = 7'b1000110;
            4'hD:    segs = 7'b0100001;
            4'hE:    segs = 7'b0000110;
            default: segs = 7'b0001110;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating per-player score counter.
//   clk, reset : clock, synchronous active-high reset (clears the score)
//   inc        : add one point this cycle (ignored once the score is at its maximum)
//   score      : current registered score
//   at_max     : score has reached 2**SCORE_W-1
module score_counter #(
    parameter int SCORE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [SCORE_W-1:0] score,
    output logic               at_max
);

    localparam logic [SCORE_W-1:0] MAX_SCORE = '1;

    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;

    always_comb begin
        score_d = score_q;
        if (inc && (score_q != MAX_SCORE)) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score  = score_q;
    assign at_max = (score_q == MAX_SCORE);

endmodule

// File: rtl/tug_referee.sv
// Round referee for the tug-of-war playfield.
// Watches the two edge lights and the conditioned L/R press pulses, declares the
// round winner, keeps both scores, drives the score digits and asks the playfield
// to restart between rounds.
//   clk, reset     : clock, synchronous active-high reset
//   L, R           : one-cycle press pulses, already synchronised
//   edge_l, edge_r : leftmost / rightmost playfield light on
//   round_reset    : restart request to the playfield (high during RESTART and DONE)
//   winner         : 00 none, 01 left, 10 right
//   score_l/_r     : per-player scores, saturating at 2**SCORE_W-1
//   hex_l/_r       : active-low 7-seg of the scores (bit0 = seg a)
//   game_over      : set when a winner's score reaches the maximum; only reset clears it
module tug_referee
    import tug_pkg::*;
#(
    parameter int SCORE_W         = 3,
    parameter int WIN_HOLD_CYCLES = 8,
    parameter int RESTART_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    input  logic               edge_l,
    input  logic               edge_r,
    output logic               round_reset,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [6:0]         hex_l,
    output logic [6:0]         hex_r,
    output logic               game_over
);

    localparam int HOLD_MAX = (WIN_HOLD_CYCLES > RESTART_CYCLES) ? WIN_HOLD_CYCLES : RESTART_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0] WIN_LOAD     = CNT_W'(WIN_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESTART_LOAD = CNT_W'(RESTART_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    winner_t          winner_q, winner_d;
    logic             round_reset_q, round_reset_d;
    logic             game_over_q, game_over_d;
    logic [6:0]       hex_l_q, hex_l_d;
    logic [6:0]       hex_r_q, hex_r_d;

    logic             inc_l, inc_r;
    logic             at_max_l, at_max_r;
    logic             left_win, right_win;
    logic             winner_at_max;
    logic [SCORE_W-1:0] score_l_nxt, score_r_nxt;

    // Simultaneous presses or both edges lit never produce a win.
    assign left_win  = edge_l & L & ~R & ~edge_r;
    assign right_win = edge_r & R & ~L & ~edge_l;

    // In WIN the score has already been incremented, so this reflects the final score.
    assign winner_at_max = (winner_q == W_LEFT) ? at_max_l : at_max_r;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        winner_d      = winner_q;
        round_reset_d = round_reset_q;
        game_over_d   = game_over_q;
        inc_l         = 1'b0;
        inc_r         = 1'b0;

        case (state_q)
            PLAY: begin
                if (left_win) begin
                    state_d  = WIN;
                    winner_d = W_LEFT;
                    inc_l    = 1'b1;
                    cnt_d    = WIN_LOAD;
                end else if (right_win) begin
                    state_d  = WIN;
                    winner_d = W_RIGHT;
                    inc_r    = 1'b1;
                    cnt_d    = WIN_LOAD;
                end
            end
            WIN: begin
                if (cnt_q == '0) begin
                    round_reset_d = 1'b1;
                    if (winner_at_max) begin
                        state_d     = DONE;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = RESTART;
                        cnt_d   = RESTART_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESTART: begin
                if (cnt_q == '0) begin
                    state_d       = PLAY;
                    round_reset_d = 1'b0;
                    winner_d      = W_NONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Terminal: only reset leaves this state.
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // The digits are registered alongside the scores, so they are decoded from the
    // scores' next values to stay in the same cycle as the score outputs.
    assign score_l_nxt = (inc_l && !at_max_l) ? score_l + SCORE_W'(1) : score_l;
    assign score_r_nxt = (inc_r && !at_max_r) ? score_r + SCORE_W'(1) : score_r;

    always_comb begin
        hex_l_d = seg7(4'(score_l_nxt));
        hex_r_d = seg7(4'(score_r_nxt));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PLAY;
            cnt_q         <= '0;
            winner_q      <= W_NONE;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            hex_l_q       <= seg7(4'h0);
            hex_r_q       <= seg7(4'h0);
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            winner_q      <= winner_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
            hex_l_q       <= hex_l_d;
            hex_r_q       <= hex_r_d;
        end
    end

    score_counter #(.SCORE_W(SCORE_W)) u_score_l (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc_l),
        .score  (score_l),
        .at_max (at_max_l)
    );

    score_counter #(.SCORE_W(SCORE_W)) u_score_r (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc_r),
        .score  (score_r),
        .at_max (at_max_r)
    );

    assign round_reset = round_reset_q;
    assign winner      = winner_q;
    assign game_over   = game_over_q;
    assign hex_l       = hex_l_q;
    assign hex_r       = hex_r_q;

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee with default parameters
// (SCORE_W=3, WIN_HOLD_CYCLES=8, RESTART_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at that point,
// so each check sees the result of the edge that just sampled the previous inputs.
module tb_tug_referee;
    import tug_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       L, R, edge_l, edge_r;
    logic       round_reset;
    logic [1:0] winner;
    logic [2:0] score_l, score_r;
    logic [6:0] hex_l, hex_r;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] HEX0 = 7'b1000000;
    localparam logic [6:0] HEX1 = 7'b1111001;
    localparam logic [6:0] HEX7 = 7'b1111000;

    tug_referee dut (
        .clk         (clk),
        .reset       (reset),
        .L           (L),
        .R           (R),
        .edge_l      (edge_l),
        .edge_r      (edge_r),
        .round_reset (round_reset),
        .winner      (winner),
        .score_l     (score_l),
        .score_r     (score_r),
        .hex_l       (hex_l),
        .hex_r       (hex_r),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_winner"}, 32'(winner), 32'(W_NONE));
        chk({tag, "_score_l"}, 32'(score_l), 0);
        chk({tag, "_score_r"}, 32'(score_r), 0);
        chk({tag, "_hex_l"}, 32'(hex_l), 32'(HEX0));
        chk({tag, "_hex_r"}, 32'(hex_r), 32'(HEX0));
        chk({tag, "_round_reset"}, 32'(round_reset), 0);
        chk({tag, "_game_over"}, 32'(game_over), 0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(PLAY));
    endtask

    task automatic press_left();
        edge_l = 1'b1; edge_r = 1'b0; L = 1'b1; R = 1'b0;
        tick();
        L = 1'b0; edge_l = 1'b0;
    endtask

    task automatic press_right();
        edge_l = 1'b0; edge_r = 1'b1; L = 1'b0; R = 1'b1;
        tick();
        R = 1'b0; edge_r = 1'b0;
    endtask

    // Bounded wait for the referee to return to PLAY after a round.
    task automatic wait_round();
        for (int i = 0; i < 40; i++) begin
            if (dut.state_q == PLAY && round_reset == 1'b0) break;
            tick();
        end
        chk("round_back_in_play", 32'(dut.state_q), 32'(PLAY));
    endtask

    initial begin
        reset = 1'b1; L = 1'b0; R = 1'b0; edge_l = 1'b0; edge_r = 1'b0;

        // 1. Reset held two cycles.
        tick();
        tick();
        chk_reset_values("reset");
        reset = 1'b0;

        // 2. Left win, hold timing, restart timing; presses during WIN/RESTART ignored.
        edge_l = 1'b1; L = 1'b1;
        tick();
        L = 1'b0;
        chk("win_winner", 32'(winner), 32'(W_LEFT));
        chk("win_score_l", 32'(score_l), 1);
        chk("win_hex_l", 32'(hex_l), 32'(HEX1));
        chk("win_round_reset", 32'(round_reset), 0);
        for (int k = 1; k <= 7; k++) begin
            L = (k == 3 || k == 5);
            tick();
            chk("hold_round_reset_low", 32'(round_reset), 0);
            chk("hold_score_l", 32'(score_l), 1);
            chk("hold_winner", 32'(winner), 32'(W_LEFT));
        end
        L = 1'b0;
        tick();
        chk("restart_round_reset_rise", 32'(round_reset), 1);
        chk("restart_winner_held", 32'(winner), 32'(W_LEFT));
        for (int k = 1; k <= 3; k++) begin
            L = (k == 2);
            tick();
            chk("restart_round_reset_high", 32'(round_reset), 1);
            chk("restart_score_l", 32'(score_l), 1);
        end
        L = 1'b0;
        tick();
        chk("back_round_reset", 32'(round_reset), 0);
        chk("back_winner", 32'(winner), 32'(W_NONE));
        chk("back_state", 32'(dut.state_q), 32'(PLAY));
        chk("back_score_l", 32'(score_l), 1);
        edge_l = 1'b0;

        // 3. Illegal / non-winning combinations.
        edge_r = 1'b1; L = 1'b1; R = 1'b1;
        tick();
        L = 1'b0; R = 1'b0; edge_r = 1'b0;
        chk("both_press_winner", 32'(winner), 32'(W_NONE));
        chk("both_press_score_r", 32'(score_r), 0);
        chk("both_press_score_l", 32'(score_l), 1);
        edge_l = 1'b1; edge_r = 1'b1; L = 1'b1;
        tick();
        L = 1'b0; edge_l = 1'b0; edge_r = 1'b0;
        chk("both_edges_winner", 32'(winner), 32'(W_NONE));
        chk("both_edges_score_l", 32'(score_l), 1);
        L = 1'b1;
        tick();
        L = 1'b0;
        chk("no_edge_winner", 32'(winner), 32'(W_NONE));
        chk("no_edge_score_l", 32'(score_l), 1);
        chk("no_edge_state", 32'(dut.state_q), 32'(PLAY));

        // Right win for coverage of the other player.
        press_right();
        chk("rwin_winner", 32'(winner), 32'(W_RIGHT));
        chk("rwin_score_r", 32'(score_r), 1);
        chk("rwin_hex_r", 32'(hex_r), 32'(HEX1));
        wait_round();

        // 4. Seven left wins from a fresh reset end the game.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            press_left();
            chk("seq_score_l", 32'(score_l), 32'(i));
            if (i < 7) wait_round();
        end
        chk("final_hex_l", 32'(hex_l), 32'(HEX7));
        chk("final_winner", 32'(winner), 32'(W_LEFT));
        for (int k = 1; k <= 7; k++) tick();
        chk("final_hold_game_over", 32'(game_over), 0);
        chk("final_hold_round_reset", 32'(round_reset), 0);
        tick();
        chk("done_game_over", 32'(game_over), 1);
        chk("done_round_reset", 32'(round_reset), 1);
        chk("done_winner", 32'(winner), 32'(W_LEFT));
        chk("done_state", 32'(dut.state_q), 32'(DONE));
        press_left();
        press_right();
        tick();
        tick();
        chk("done_ignore_score_l", 32'(score_l), 7);
        chk("done_ignore_score_r", 32'(score_r), 0);
        chk("done_ignore_round_reset", 32'(round_reset), 1);
        chk("done_ignore_game_over", 32'(game_over), 1);

        // 5a. Reset during DONE.
        reset = 1'b1;
        tick();
        chk_reset_values("rst_done");
        reset = 1'b0;

        // 5b. Reset during RESTART.
        press_right();
        chk("pre_restart_score_r", 32'(score_r), 1);
        for (int k = 1; k <= 8; k++) tick();
        chk("in_restart_round_reset", 32'(round_reset), 1);
        reset = 1'b1;
        tick();
        chk_reset_values("rst_restart");
        reset = 1'b0;

        // Play resumes normally after the abort.
        press_left();
        chk("resume_score_l", 32'(score_l), 1);
        chk("resume_winner", 32'(winner), 32'(W_LEFT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
